// File: rtl/lsu_mem_port.sv
// Load/store port toward a word-organised data memory. Handles one request at
// a time, performs sub-word stores as read-modify-write and returns a tagged
// response (load data, store done or exception).
module lsu_mem_port #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_WIDTH  = 6,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_store_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    input  logic                  flush_i,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [2:0]            mem_funct3_o,
    output logic                  mem_read_en_o,
    output logic                  mem_write_en_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rdata_valid_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [TAG_WIDTH-1:0]  resp_tag_o,
    output logic                  resp_is_store_o,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic                  resp_exc_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  F3Word = 3'b010;

    typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWr, StResp} state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [15:0]             wdata_q;   // only the low half is needed for merging
    logic                    half_q;    // sub-word store is SH (1) or SB (0)

    logic                    req_ready_q;
    logic [ADDR_WIDTH-1:0]   mem_raddr_q;
    logic [ADDR_WIDTH-1:0]   mem_waddr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [2:0]              mem_funct3_q;
    logic                    mem_read_en_q;
    logic                    mem_write_en_q;
    logic                    resp_valid_q;
    logic [TAG_WIDTH-1:0]    resp_tag_q;
    logic                    resp_is_store_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    resp_exc_q;

    logic                    req_illegal;
    logic                    req_misaligned;
    logic [DATA_WIDTH-1:0]   merged_word;

    // Classify the incoming request: illegal funct3 or misaligned address.
    always_comb begin
        req_illegal = 1'b0;
        if (req_is_store_i) begin
            req_illegal = (req_funct3_i > 3'd2);
        end else begin
            req_illegal = (req_funct3_i == 3'd3) || (req_funct3_i == 3'd6) ||
                          (req_funct3_i == 3'd7);
        end
        req_misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                         ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    end

    // Merge store data into the old word read back from memory.
    always_comb begin
        merged_word = mem_rdata_i;
        if (half_q) begin
            if (addr_q[1]) merged_word[31:16] = wdata_q;
            else           merged_word[15:0]  = wdata_q;
        end else begin
            case (addr_q[1:0])
                2'd0:    merged_word[7:0]   = wdata_q[7:0];
                2'd1:    merged_word[15:8]  = wdata_q[7:0];
                2'd2:    merged_word[23:16] = wdata_q[7:0];
                default: merged_word[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Access sequencer: state plus all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            half_q          <= 1'b0;
            req_ready_q     <= 1'b1;
            mem_raddr_q     <= '0;
            mem_waddr_q     <= '0;
            mem_wdata_q     <= '0;
            mem_funct3_q    <= '0;
            mem_read_en_q   <= 1'b0;
            mem_write_en_q  <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_tag_q      <= '0;
            resp_is_store_q <= 1'b0;
            resp_data_q     <= '0;
            resp_exc_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // A flush coinciding with a request drops it.
                    if (req_valid_i && !flush_i) begin
                        addr_q          <= req_addr_i;
                        wdata_q         <= req_wdata_i[15:0];
                        half_q          <= req_funct3_i[0];
                        req_ready_q     <= 1'b0;
                        resp_tag_q      <= req_tag_i;
                        resp_is_store_q <= req_is_store_i;
                        resp_data_q     <= '0;
                        resp_exc_q      <= 1'b0;
                        if (req_illegal || req_misaligned) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_exc_q   <= 1'b1;
                        end else if (!req_is_store_i) begin
                            state_q       <= StRdReq;
                            mem_read_en_q <= 1'b1;
                            mem_raddr_q   <= req_addr_i;
                            mem_funct3_q  <= req_funct3_i;
                        end else if (req_funct3_i == F3Word) begin
                            state_q        <= StWr;
                            mem_write_en_q <= 1'b1;
                            mem_waddr_q    <= {2'b00, req_addr_i[ADDR_WIDTH-1:2]};
                            mem_wdata_q    <= req_wdata_i;
                        end else begin
                            // Sub-word store: fetch the enclosing word first.
                            state_q       <= StRdReq;
                            mem_read_en_q <= 1'b1;
                            mem_raddr_q   <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_funct3_q  <= F3Word;
                        end
                    end
                end
                StRdReq: begin
                    if (flush_i) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end else begin
                        state_q <= StRdWait;
                    end
                end
                StRdWait: begin
                    if (flush_i) begin
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b1;
                    end else if (mem_rdata_valid_i) begin
                        cnt_q <= '0;
                        if (resp_is_store_q) begin
                            state_q        <= StWr;
                            mem_write_en_q <= 1'b1;
                            mem_waddr_q    <= {2'b00, addr_q[ADDR_WIDTH-1:2]};
                            mem_wdata_q    <= merged_word;
                        end else begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= mem_rdata_i;
                        end
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        state_q      <= StResp;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_exc_q   <= 1'b1;
                        resp_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWr: begin
                    // The write strobe is already out; a flush only hides the response.
                    if (flush_i) begin
                        state_q     <= StIdle;
                        req_ready_q <= 1'b1;
                    end else begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (flush_i || resp_ready_i) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign mem_raddr_o     = mem_raddr_q;
    assign mem_waddr_o     = mem_waddr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_funct3_o    = mem_funct3_q;
    assign mem_read_en_o   = mem_read_en_q;
    assign mem_write_en_o  = mem_write_en_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_tag_o      = resp_tag_q;
    assign resp_is_store_o = resp_is_store_q;
    assign resp_data_o     = resp_data_q;
    assign resp_exc_o      = resp_exc_q;

endmodule
